// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the sequencer that executes it:
// operand/result/address types, the instruction word, opcodes and sequencer states.
package instr_register_pkg;

  localparam int NUM_ENTRIES = 32;

  typedef logic [4:0]          address_t;
  typedef logic signed [31:0]  operand_t;
  typedef logic signed [63:0]  rezultat;

  // Encodings 8..15 are undefined and produce an error result.
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    OUT   = 2'd3
  } seq_state_t;

  // The register file has exactly 32 entries, so the pointer wraps naturally.
  function automatic address_t next_pointer(input address_t p);
    return address_t'(p + 5'd1);
  endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational arithmetic for one instruction: signed 32-bit operands,
// exact 64-bit results, error flag for divide/modulo by zero and bad opcodes.
module instr_alu
  import instr_register_pkg::*;
(
  input  opcode_t  opc,
  input  operand_t a,
  input  operand_t b,
  output rezultat  res,
  output logic     err
);

  rezultat a_ext;
  rezultat b_ext;
  logic    b_zero;

  // Working in 64 bits keeps ADD/SUB exact and makes INT_MIN / -1 representable.
  assign a_ext  = {{32{a[31]}}, a};
  assign b_ext  = {{32{b[31]}}, b};
  assign b_zero = (b == '0);

  always_comb begin
    res = '0;
    err = 1'b0;
    case (opc)
      ZERO:  res = '0;
      PASSA: res = a_ext;
      PASSB: res = b_ext;
      ADD:   res = a_ext + b_ext;
      SUB:   res = a_ext - b_ext;
      MULT:  res = a_ext * b_ext;
      DIV: begin
        if (b_zero) err = 1'b1;
        else        res = a_ext / b_ext;
      end
      MOD: begin
        if (b_zero) err = 1'b1;
        else        res = a_ext % b_ext;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_exec_sequencer.sv
// Walks a run of instruction-register entries, executing one per FETCH/EXEC/OUT
// pass and presenting each result on a valid/ready interface.
module instr_exec_sequencer
  import instr_register_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  address_t     first_addr,
  input  logic [5:0]   count,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         res_valid,
  input  logic         res_ready,
  output rezultat      res_data,
  output address_t     res_addr,
  output logic         res_err,
  output logic         busy,
  output logic         done
);

  seq_state_t   state_reg;
  seq_state_t   state_next;
  address_t     pointer_reg;
  logic [5:0]   remaining_reg;
  instruction_t instr_latch_reg;
  rezultat      res_data_reg;
  address_t     res_addr_reg;
  logic         res_err_reg;
  logic         done_reg;

  rezultat      alu_res;
  logic         alu_err;
  logic         launch;
  logic         handshake;
  logic         last_one;

  assign launch    = (state_reg == IDLE) && start && (count != 6'd0);
  assign handshake = (state_reg == OUT) && res_ready;
  assign last_one  = (remaining_reg == 6'd1);

  instr_alu u_alu (
    .opc (instr_latch_reg.opc),
    .a   (instr_latch_reg.op_a),
    .b   (instr_latch_reg.op_b),
    .res (alu_res),
    .err (alu_err)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = FETCH;
      FETCH:   state_next = EXEC;
      EXEC:    state_next = OUT;
      OUT:     if (res_ready) state_next = last_one ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    res_valid = (state_reg == OUT);
    busy      = (state_reg != IDLE);
  end

  // The pointer only moves on launch and on an accepted result, so it stays
  // stable through EXEC and any backpressure in OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer_reg     <= '0;
      remaining_reg   <= '0;
      instr_latch_reg <= '0;
      res_data_reg    <= '0;
      res_addr_reg    <= '0;
      res_err_reg     <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= handshake && last_one;
      if (launch) begin
        pointer_reg   <= first_addr;
        remaining_reg <= count;
      end
      if (state_reg == FETCH) begin
        instr_latch_reg <= instruction_word;
      end
      if (state_reg == EXEC) begin
        res_data_reg <= alu_res;
        res_err_reg  <= alu_err;
        res_addr_reg <= pointer_reg;
      end
      if (handshake) begin
        remaining_reg <= remaining_reg - 6'd1;
        pointer_reg   <= next_pointer(pointer_reg);
      end
    end
  end

  assign read_pointer = pointer_reg;
  assign res_data     = res_data_reg;
  assign res_addr     = res_addr_reg;
  assign res_err      = res_err_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Bench for instr_exec_sequencer: fixed vector table, hand-written corner
// sequences, and randomized runs against a queue-based reference model.
module tb_instr_exec_sequencer;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  address_t     first_addr;
  logic [5:0]   count;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         res_valid;
  logic         res_ready;
  rezultat      res_data;
  address_t     res_addr;
  logic         res_err;
  logic         busy;
  logic         done;

  instruction_t mem [NUM_ENTRIES];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] opc;
    int         a;
    int         b;
    longint     data;
    bit         err;
  } vec_t;

  typedef struct {
    address_t addr;
    longint   data;
    bit       err;
  } exp_t;

  vec_t tbl [15];

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  instr_exec_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_addr         (res_addr),
    .res_err          (res_err),
    .busy             (busy),
    .done             (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Reference semantics: exact signed arithmetic, division by magnitudes.
  function automatic void model(input instruction_t w, output longint d, output bit e);
    longint a, b, q, ma, mb;
    a = longint'(w.op_a);
    b = longint'(w.op_b);
    d = 0;
    e = 0;
    case (int'(w.opc))
      0: d = 0;
      1: d = a;
      2: d = b;
      3: d = a + b;
      4: d = a - b;
      5: d = a * b;
      6, 7: begin
        if (b == 0) e = 1;
        else begin
          ma = (a < 0) ? -a : a;
          mb = (b < 0) ? -b : b;
          q  = ma / mb;
          if ((a < 0) != (b < 0)) q = -q;
          d = (int'(w.opc) == 6) ? q : a - q * b;
        end
      end
      default: e = 1;
    endcase
  endfunction

  task automatic load_table();
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (i < 15) begin
        mem[i].opc  = opcode_t'(tbl[i].opc);
        mem[i].op_a = operand_t'(tbl[i].a);
        mem[i].op_b = operand_t'(tbl[i].b);
      end else begin
        mem[i] = '0;
      end
    end
  endtask

  task automatic randomize_mem();
    int a, b;
    logic [3:0] o;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      o = ($urandom_range(9) < 8) ? 4'($urandom_range(7)) : 4'($urandom_range(15, 8));
      a = ($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(40)) - 20;
      b = ($urandom_range(4) == 0) ? 0 :
          (($urandom_range(3) == 0) ? int'($urandom) : int'($urandom_range(40)) - 20);
      mem[i].opc  = opcode_t'(o);
      mem[i].op_a = operand_t'(a);
      mem[i].op_b = operand_t'(b);
    end
  endtask

  // Run entries first..first+n-1 of the table with res_ready high; exact cycle timing.
  task automatic run_table(input int first, input int n);
    res_ready  = 1'b1;
    first_addr = address_t'(first);
    count      = 6'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fetch_busy", 64'(busy), 64'd1);
    chk("fetch_no_valid", 64'(res_valid), 64'd0);
    for (int i = 0; i < n; i++) begin
      repeat ((i == 0) ? 2 : 3) @(posedge clk);
      #1;
      chk($sformatf("tbl_valid[%0d]", first + i), 64'(res_valid), 64'd1);
      chk($sformatf("tbl_data[%0d]", first + i), res_data, 64'(tbl[first + i].data));
      chk($sformatf("tbl_err[%0d]", first + i), 64'(res_err), 64'(tbl[first + i].err));
      chk($sformatf("tbl_addr[%0d]", first + i), 64'(res_addr), 64'(first + i));
    end
    @(posedge clk); #1;
    chk("tbl_done", 64'(done), 64'd1);
    chk("tbl_idle", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("tbl_done_one_cycle", 64'(done), 64'd0);
    res_ready = 1'b0;
  endtask

  task automatic hold_test();
    address_t rp, ad;
    rezultat  d;
    logic     e;
    int       w;
    res_ready  = 1'b0;
    first_addr = 5'd0;
    count      = 6'd2;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!res_valid && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    chk("hold_reach_out", 64'(res_valid), 64'd1);
    chk("hold_first_data", res_data, 64'd8);
    rp = read_pointer;
    d  = res_data;
    ad = res_addr;
    e  = res_err;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", res_data, d);
      chk("hold_addr", 64'(res_addr), 64'(ad));
      chk("hold_err", 64'(res_err), 64'(e));
      chk("hold_ptr", 64'(read_pointer), 64'(rp));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("hold_ptr_advance", 64'(read_pointer), 64'(address_t'(rp + 5'd1)));
    chk("hold_valid_drop", 64'(res_valid), 64'd0);
    chk("hold_still_busy", 64'(busy), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_second_valid", 64'(res_valid), 64'd1);
    chk("hold_second_data", res_data, 64'(-64'sd7));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("hold_done", 64'(done), 64'd1);
  endtask

  task automatic reset_test();
    res_ready  = 1'b1;
    first_addr = 5'd0;
    count      = 6'd3;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_no_valid", 64'(res_valid), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(res_valid), 64'd0);
    chk("abort_data", res_data, 64'd0);
    chk("abort_ptr", 64'(read_pointer), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_stays_idle", 64'(busy), 64'd0);
    end
  endtask

  task automatic noop_test();
    address_t rp;
    rp         = read_pointer;
    first_addr = 5'd7;
    count      = 6'd0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("noop_busy", 64'(busy), 64'd0);
    chk("noop_ptr", 64'(read_pointer), 64'(rp));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("noop_no_done", 64'(done), 64'd0);
      chk("noop_idle", 64'(busy), 64'd0);
    end
  endtask

  // Random backpressure and stray start pulses while busy; results checked
  // in order against the model's queue of expected {addr, data, err}.
  task automatic run_random(input address_t first, input int cnt, input int ready_pct);
    exp_t     q[$];
    exp_t     x;
    bit       hs_prev, held, finished, rdy;
    address_t rp;
    rezultat  d;
    address_t ad;
    logic     e;
    for (int i = 0; i < cnt; i++) begin
      x.addr = address_t'((int'(first) + i) % NUM_ENTRIES);
      model(mem[x.addr], x.data, x.err);
      q.push_back(x);
    end
    first_addr = first;
    count      = 6'(cnt);
    start      = 1'b1;
    hs_prev    = 0;
    held       = 0;
    finished   = 0;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(posedge clk); #1;
      if (hs_prev && q.size() == 0) begin
        chk("rnd_done", 64'(done), 64'd1);
        chk("rnd_idle_after_last", 64'(busy), 64'd0);
        finished = 1;
      end else begin
        chk("rnd_no_early_done", 64'(done), 64'd0);
        if (held) begin
          chk("rnd_hold_valid", 64'(res_valid), 64'd1);
          chk("rnd_hold_data", res_data, d);
          chk("rnd_hold_addr", 64'(res_addr), 64'(ad));
          chk("rnd_hold_err", 64'(res_err), 64'(e));
          chk("rnd_hold_ptr", 64'(read_pointer), 64'(rp));
        end
        rdy       = ($urandom_range(99) < ready_pct);
        res_ready = rdy;
        hs_prev   = 0;
        held      = 0;
        if (res_valid && rdy) begin
          chk("rnd_result_expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            x = q.pop_front();
            chk($sformatf("rnd_addr@%0d", x.addr), 64'(res_addr), 64'(x.addr));
            chk($sformatf("rnd_data@%0d", x.addr), res_data, 64'(x.data));
            chk($sformatf("rnd_err@%0d", x.addr), 64'(res_err), 64'(x.err));
          end
          hs_prev = 1;
        end else if (res_valid) begin
          held = 1;
          d    = res_data;
          ad   = res_addr;
          e    = res_err;
          rp   = read_pointer;
        end
        start      = busy && ($urandom_range(7) == 0);
        first_addr = address_t'($urandom);
        count      = 6'($urandom);
      end
    end
    start     = 1'b0;
    res_ready = 1'b0;
    if (!finished) chk("rnd_run_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    tbl[0]  = '{4'd3, 5, 3, 64'sd8, 1'b0};
    tbl[1]  = '{4'd4, 2, 9, -64'sd7, 1'b0};
    tbl[2]  = '{4'd5, -4, 6, -64'sd24, 1'b0};
    tbl[3]  = '{4'd1, -5, 11, -64'sd5, 1'b0};
    tbl[4]  = '{4'd6, 7, 0, 64'sd0, 1'b1};
    tbl[5]  = '{4'd7, -7, 2, -64'sd1, 1'b0};
    tbl[6]  = '{4'd6, -7, 2, -64'sd3, 1'b0};
    tbl[7]  = '{4'd7, 7, -2, 64'sd1, 1'b0};
    tbl[8]  = '{4'd2, 3, -9, -64'sd9, 1'b0};
    tbl[9]  = '{4'd0, 100, 200, 64'sd0, 1'b0};
    tbl[10] = '{4'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'sh3FFF_FFFF_0000_0001, 1'b0};
    tbl[11] = '{4'd6, 32'h8000_0000, -1, 64'sd2147483648, 1'b0};
    tbl[12] = '{4'd11, 1, 2, 64'sd0, 1'b1};
    tbl[13] = '{4'd4, 32'h8000_0000, 1, 64'shFFFF_FFFF_7FFF_FFFF, 1'b0};
    tbl[14] = '{4'd7, 5, 0, 64'sd0, 1'b1};

    reset      = 1'b1;
    start      = 1'b0;
    res_ready  = 1'b0;
    first_addr = '0;
    count      = '0;
    load_table();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ptr", 64'(read_pointer), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_data", res_data, 64'd0);
    chk("rst_addr", 64'(res_addr), 64'd0);
    chk("rst_err", 64'(res_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    start = 1'b1;
    count = 6'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_beats_start", 64'(busy), 64'd0);
    reset = 1'b0;

    run_table(0, 3);
    run_table(3, 12);
    hold_test();
    reset_test();
    run_table(0, 3);
    noop_test();

    randomize_mem();
    run_random(5'd30, 4, 100);
    for (int r = 0; r < 20; r++) begin
      int pct;
      randomize_mem();
      pct = (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 50 : 30);
      run_random(address_t'($urandom), int'($urandom_range(32, 1)), pct);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
